// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order writeback queue and pending-write scoreboard
// feeding the single write port (RD, WriteData, RegWrite) of the register file.
// Two producers (load unit, ALU) push into a DEPTH-entry circular FIFO. The FIFO
// retires at most one entry per cycle. A 32 x 3-bit pending counter array
// flags read-after-write hazards for the issue stage.
// Optional feature macro: WB_DROP_X0_EN. When it is defined, results and
// allocations for register 0 are swallowed and register 0 never reads busy.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic [4:0]                 RD,
    output logic [XLEN-1:0]            WriteData,
    output logic                       RegWrite,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sb_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue storage and control
    logic [4:0]      r_q_rd   [DEPTH];
    logic [XLEN-1:0] r_q_data [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // Write-port output registers
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wdata;
    logic            r_regwrite;

    // Scoreboard
    logic [2:0]      r_pend      [32];
    logic [2:0]      w_pend_next [32];
    logic            r_sb_err;
    logic            w_err_set;

    logic [CW-1:0]   w_free;
    logic            w_mem_needs;
    logic            w_alu_needs;
    logic            w_alloc_en;
    logic            w_mem_push;
    logic            w_alu_push;
    logic            w_pop;
    logic [AW-1:0]   w_alu_slot;

`ifdef WB_DROP_X0_EN
    // Register 0 results complete the handshake but never occupy a slot.
    assign w_mem_needs = (mem_rd != 5'd0);
    assign w_alu_needs = (alu_rd != 5'd0);
    assign w_alloc_en  = alloc_valid & (alloc_rd != 5'd0);
    assign rs1_busy    = (chk_rs1 != 5'd0) & (r_pend[chk_rs1] != 3'd0);
    assign rs2_busy    = (chk_rs2 != 5'd0) & (r_pend[chk_rs2] != 3'd0);
`else
    // Register 0 is an ordinary register in this build.
    assign w_mem_needs = 1'b1;
    assign w_alu_needs = 1'b1;
    assign w_alloc_en  = alloc_valid;
    assign rs1_busy    = (r_pend[chk_rs1] != 3'd0);
    assign rs2_busy    = (r_pend[chk_rs2] != 3'd0);
`endif

    // Free slots come from the registered count only; a same-cycle pop gives no credit.
    assign w_free    = CW'(DEPTH) - r_count;
    assign mem_ready = !w_mem_needs | (w_free != '0);
    // The load unit has priority on the last free slot.
    assign alu_ready = !w_alu_needs | (w_free >= CW'(2))
                     | ((w_free == CW'(1)) & !(mem_valid & w_mem_needs));

    assign w_mem_push = mem_valid & mem_ready & w_mem_needs;
    assign w_alu_push = alu_valid & alu_ready & w_alu_needs;
    assign w_pop      = (r_count != '0);
    // The ALU entry lands behind the load entry when both push together.
    assign w_alu_slot = r_tail + AW'(w_mem_push);

    assign count     = r_count;
    assign RD        = r_rd;
    assign WriteData = r_wdata;
    assign RegWrite  = r_regwrite;
    assign sb_err    = r_sb_err;

    // Queue payload writes
    // NOTE: payload storage has no reset; the count says which slots are valid, so stale data is never read.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_q_rd[r_tail]   <= mem_rd;
            r_q_data[r_tail] <= mem_data;
        end
        if (w_alu_push) begin
            r_q_rd[w_alu_slot]   <= alu_rd;
            r_q_data[w_alu_slot] <= alu_data;
        end
    end

    // Pointers, occupancy and the write-port output registers
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_regwrite <= 1'b0;
        end else begin
            r_head     <= r_head + AW'(w_pop);
            r_tail     <= r_tail + AW'(w_mem_push) + AW'(w_alu_push);
            r_count    <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
            r_regwrite <= w_pop;
            if (w_pop) begin
                r_rd    <= r_q_rd[r_head];
                r_wdata <= r_q_data[r_head];
            end
        end
    end

    // Next pending counts: alloc increments, a presented write decrements, both cancel
    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        w_err_set = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_pend_next[i] = r_pend[i];
            if ((w_alloc_en && alloc_rd == 5'(i)) && !(r_regwrite && r_rd == 5'(i))) begin
                if (r_pend[i] == 3'd7) w_err_set = 1'b1;
                else                   w_pend_next[i] = r_pend[i] + 3'd1;
            end else if ((r_regwrite && r_rd == 5'(i)) && !(w_alloc_en && alloc_rd == 5'(i))) begin
                if (r_pend[i] == 3'd0) w_err_set = 1'b1;
                else                   w_pend_next[i] = r_pend[i] - 3'd1;
            end
        end
    end

    // Scoreboard counters and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_pend[i] <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_pend   <= w_pend_next;
            r_sb_err <= r_sb_err | w_err_set;
        end
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback queue and scoreboard that drives the 64-bit register file's single write port (RD, WriteData, RegWrite). It sits between the execute stage and the register file. It collects results from two producers, the ALU and the multi-cycle load unit, buffers them in a small in-order FIFO, and retires at most one write per cycle. It also keeps a per-register pending-write scoreboard so the issue stage can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥ 2)
- XLEN, 64, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- mem_valid  in  1  load-unit result valid
- mem_ready  out  1  load-unit result accepted when valid & ready
- mem_rd  in  5  load destination register
- mem_data  in  XLEN  load result
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted when valid & ready
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- RD  out  5  register-file write address
- WriteData  out  XLEN  register-file write data
- RegWrite  out  1  register-file write enable
- alloc_valid  in  1  issue stage reserves a destination register
- alloc_rd  in  5  reserved register
- chk_rs1, chk_rs2  in  5 each  source registers to check
- rs1_busy, rs2_busy  out  1 each  pending write exists for chk_rs1/chk_rs2
- count  out  clog2(DEPTH)+1  occupied queue entries
- sb_err  out  1  sticky scoreboard overflow/underflow flag

## Operation
- Queue is an in-order circular FIFO with head/tail pointers and an occupancy count. Free slots: free = DEPTH − count. The count is the registered value; a pop in the same cycle gives no credit.
- mem_ready = (free ≥ 1).
- alu_ready = (free ≥ 2) | (free == 1 & !mem_valid). A combinational path from mem_valid to alu_ready is permitted.
- Simultaneous accept: the mem entry enqueues first, then the ALU entry. Both are written in one edge and count increases by 2.
- Drain: each edge with count ≠ 0 pops the head into the RD/WriteData output registers and sets RegWrite=1. With count == 0, RegWrite=0. RD and WriteData hold their last values.
- Push and pop in the same edge are allowed. The count changes by (pushes − pop).
- Scoreboard: 32 × 3-bit pending counters.
  - alloc_valid increments pend[alloc_rd].
  - An edge with RegWrite=1 decrements pend[RD].
  - If both target the same register in the same edge, that counter is unchanged.
- rsN_busy = (pend[chk_rsN] ≠ 0), combinational. A register whose write is being presented this cycle still reads busy. It clears after the edge.
- sb_err is set (sticky until reset) on either condition. The counter saturates and does not wrap.
  - alloc to a counter already at 7.
  - decrement of a counter at 0.
- Producers do not check the scoreboard. Issue must call alloc once per result it will later deliver.

## Timing
- Reset values: RegWrite=0, RD=0, WriteData=0, count=0, head=tail=0, all pend=0, sb_err=0.
- After reset: mem_ready=1 and alu_ready=1 (with DEPTH ≥ 2).
- Latency:
  - Handshake at edge N enqueues the entry.
  - If it is the head, it is popped at N+1 and RegWrite is high during cycle N+1→N+2.
  - The register file writes at edge N+2.
- Throughput: one retire per cycle. Sustained input of two results per cycle fills the queue; the ready signals then throttle producers.
- Pointers wrap modulo DEPTH. Full state is count == DEPTH; there is no pointer-equality ambiguity.
- Reset asserted mid-operation: queued entries are discarded and RegWrite drops asynchronously. Pending counters clear.

## Configuration
- WB_DROP_X0_EN defined:
  - Results with rd == 0 are accepted (ready/valid handshake completes) but not enqueued. They do not count toward free-slot checks for that cycle.
  - alloc with alloc_rd == 0 is ignored.
  - rs*_busy is 0 for register 0.
  - RegWrite is never asserted with RD == 0.
- WB_DROP_X0_EN undefined: register 0 is treated exactly like registers 1–31, because the register file does not hardwire it.

## Test plan
- Reset, then alloc rd=5, then alu result (rd=5, data=0x1234) at edge N → RegWrite=1, RD=5, WriteData=0x1234 in cycle N+1; rs1_busy (chk_rs1=5) is 1 until edge N+2, then 0.
- mem (rd=3, 0xAA) and alu (rd=4, 0xBB) valid in the same cycle on an empty queue → both accepted; writes retire rd=3 on the first cycle, rd=4 on the next.
- Hold both producers valid for 10 cycles with DEPTH=4 → count never exceeds 4; alu_ready=0 whenever free<2 and mem_valid=1; retire order matches acceptance order, mem before alu per cycle; pointers wrap correctly.
- Assert reset low mid-stream with count=3 → RegWrite=0 immediately, count=0, busy outputs 0; no further writes after release.
- Eight allocs to rd=7 with no retires → pend saturates at 7 and sb_err=1; a retire to an unallocated register also sets sb_err.
- rd=0 alu result with WB_DROP_X0_EN defined → handshake completes, count stays 0, RegWrite stays 0. Without the macro → RegWrite=1 with RD=0.
